// File: rtl/fifo_wr_occupancy.sv
// fifo_wr_occupancy: write-domain status block for an asynchronous FIFO.
// Synchronizes the Gray read pointer into wr_clk, converts it to binary and
// derives registered occupancy, free space and almost-full. Also tracks
// attempted writes while full (sticky flag plus saturating counter).
// Optional build macro FIFO_WR_PTR_CHECK_EN adds a sticky pointer-consistency
// error (read pointer ahead of write pointer); without it ptr_err is tied to 0.
module fifo_wr_occupancy #(
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = FIFO_DEPTH - 1,
    localparam int A           = $clog2(FIFO_DEPTH),
    localparam int PW          = A + 1
) (
    input  logic          wr_clk,
    input  logic          wr_rst_n,
    input  logic [PW-1:0] rptr_gray_async,
    input  logic [PW-1:0] wptr_bin,
    input  logic          wr_en,
    input  logic          full,
    input  logic          ovf_clr,
    output logic [PW-1:0] rptr_gray_sync,
    output logic [PW-1:0] rptr_bin_sync,
    output logic [PW-1:0] wr_level,
    output logic [PW-1:0] wr_free,
    output logic          almost_full,
    output logic          overflow,
    output logic [7:0]    ovf_cnt,
    output logic          ptr_err
);

    localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] THRESH_P = PW'(AFULL_THRESH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "fifo_wr_occupancy: FIFO_DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "fifo_wr_occupancy: SYNC_STAGES must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_thresh
        $fatal(1, "fifo_wr_occupancy: AFULL_THRESH must be in 1..FIFO_DEPTH");
    end

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] rbin_q;
    logic [PW-1:0] level_d, level_q;
    logic [PW-1:0] free_d, free_q;
    logic          afull_d, afull_q;
    logic          ovf_d, ovf_q;
    logic [7:0]    cnt_d, cnt_q;
    logic          viol;

    // Plain flop chain for the read pointer; no logic between stages.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Registered Gray-to-binary conversion of the last synchronizer stage.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) rbin_q <= '0;
        else           rbin_q <= gray2bin(sync_q[SYNC_STAGES-1]);
    end

    // Modulo subtraction handles pointer wrap without any special case.
    always_comb begin
        level_d = wptr_bin - rbin_q;
        free_d  = DEPTH_P - level_d;
        afull_d = (level_d >= THRESH_P);
    end

    // Occupancy, free space and almost-full all update on the same edge.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            level_q <= '0;
            free_q  <= DEPTH_P;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            free_q  <= free_d;
            afull_q <= afull_d;
        end
    end

    // Overflow bookkeeping: a violation on the same edge as a clear wins.
    always_comb begin
        viol  = wr_en & full;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (viol) begin
            ovf_d = 1'b1;
            cnt_d = ovf_clr ? 8'd1 : sat_inc(cnt_q);
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
            cnt_d = 8'd0;
        end
    end

    // Overflow status registers.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            ovf_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef FIFO_WR_PTR_CHECK_EN
    logic ptr_err_q;

    // Sticky error once the read pointer has passed the write pointer.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n)                ptr_err_q <= 1'b0;
        else if (level_d > DEPTH_P)   ptr_err_q <= 1'b1;
    end

    assign ptr_err = ptr_err_q;
`else
    assign ptr_err = 1'b0;
`endif

    assign rptr_gray_sync = sync_q[SYNC_STAGES-1];
    assign rptr_bin_sync  = rbin_q;
    assign wr_level       = level_q;
    assign wr_free        = free_q;
    assign almost_full    = afull_q;
    assign overflow       = ovf_q;
    assign ovf_cnt        = cnt_q;

endmodule

// File: tb/tb_fifo_wr_occupancy.sv
// Testbench for fifo_wr_occupancy (FIFO_DEPTH=4, SYNC_STAGES=2, AFULL_THRESH=3).
module tb_fifo_wr_occupancy;

    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int TH    = 3;

    logic       wr_clk = 1'b0;
    logic       wr_rst_n = 1'b0;
    logic [2:0] rptr_gray_async = '0;
    logic [2:0] wptr_bin = '0;
    logic       wr_en = 1'b0;
    logic       full = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] rptr_gray_sync, rptr_bin_sync, wr_level, wr_free;
    logic       almost_full, overflow, ptr_err;
    logic [7:0] ovf_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: rptr history (index 0 = value sampled at the latest edge)
    int rh[$];
    int m_ovf, m_cnt, m_perr;

    fifo_wr_occupancy #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(S), .AFULL_THRESH(TH)) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
        .rptr_gray_async(rptr_gray_async), .wptr_bin(wptr_bin),
        .wr_en(wr_en), .full(full), .ovf_clr(ovf_clr),
        .rptr_gray_sync(rptr_gray_sync), .rptr_bin_sync(rptr_bin_sync),
        .wr_level(wr_level), .wr_free(wr_free), .almost_full(almost_full),
        .overflow(overflow), .ovf_cnt(ovf_cnt), .ptr_err(ptr_err)
    );

    always #5 wr_clk = ~wr_clk;

    // Gray decode by search: the binary value whose Gray code equals g.
    function automatic int g2b(input int g);
        for (int b = 0; b < 8; b++) if ((b ^ (b >> 1)) == g) return b;
        return 0;
    endfunction

    function automatic int hist(input int k);
        return (k < rh.size()) ? rh[k] : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rh.delete();
        m_ovf = 0; m_cnt = 0; m_perr = 0;
    endtask

    task automatic check_all(input int wp);
        int lvl;
        lvl = (wp - g2b(hist(S + 1))) & 7;
        chk("gray_sync", rptr_gray_sync, hist(S - 1));
        chk("bin_sync", rptr_bin_sync, g2b(hist(S)));
        chk("wr_level", wr_level, lvl);
        chk("wr_free", wr_free, (DEPTH - lvl) & 7);
        chk("almost_full", almost_full, (lvl >= TH) ? 1 : 0);
        chk("overflow", overflow, m_ovf);
        chk("ovf_cnt", ovf_cnt, m_cnt);
        chk("ptr_err", ptr_err, m_perr);
    endtask

    // Apply inputs, clock one edge, advance the model and compare everything.
    task automatic step(input int wp, input int rg, input bit we, input bit fu, input bit clr);
        int lvl;
        wptr_bin = 3'(wp); rptr_gray_async = 3'(rg);
        wr_en = we; full = fu; ovf_clr = clr;
        @(posedge wr_clk);
        #1;
        rh.push_front(rg);
        if (we && fu) begin
            m_ovf = 1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_ovf = 0; m_cnt = 0;
        end
        lvl = (wp - g2b(hist(S + 1))) & 7;
`ifdef FIFO_WR_PTR_CHECK_EN
        if (lvl > DEPTH) m_perr = 1;
`endif
        check_all(wp);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gray"}, rptr_gray_sync, 0);
        chk({tag, "_bin"}, rptr_bin_sync, 0);
        chk({tag, "_level"}, wr_level, 0);
        chk({tag, "_free"}, wr_free, DEPTH);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_cnt"}, ovf_cnt, 0);
        chk({tag, "_perr"}, ptr_err, 0);
    endtask

    initial begin
        int wp, rg;
        model_reset();
        // Reset held with all inputs low.
        repeat (3) @(posedge wr_clk);
        #1 check_reset_vals("rst");
        @(negedge wr_clk) wr_rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("idle_level", wr_level, 0);
        chk("idle_free", wr_free, 4);

        // Write pointer change appears after one edge.
        step(3, 0, 0, 0, 0);
        chk("w3_level", wr_level, 3);
        chk("w3_free", wr_free, 1);
        chk("w3_afull", almost_full, 1);

        // Read pointer latency through sync, decode and level stages.
        step(3, 3, 0, 0, 0);
        step(3, 3, 0, 0, 0);
        chk("lat_gray", rptr_gray_sync, 3);
        step(3, 3, 0, 0, 0);
        chk("lat_bin", rptr_bin_sync, 2);
        chk("lat_level_old", wr_level, 3);
        step(3, 3, 0, 0, 0);
        chk("lat_level", wr_level, 1);
        chk("lat_afull", almost_full, 0);

        // Wrap: pointers with differing MSBs.
        repeat (5) step(1, 7, 0, 0, 0);
        chk("wrap_level", wr_level, 4);
        chk("wrap_free", wr_free, 0);
        chk("wrap_afull", almost_full, 1);

        // Overflow sequence.
        repeat (3) step(1, 7, 1, 1, 0);
        chk("ovf3_flag", overflow, 1);
        chk("ovf3_cnt", ovf_cnt, 3);
        step(1, 7, 1, 1, 1);
        chk("ovf_setwins_flag", overflow, 1);
        chk("ovf_setwins_cnt", ovf_cnt, 1);
        step(1, 7, 0, 0, 1);
        chk("ovf_clr_flag", overflow, 0);
        chk("ovf_clr_cnt", ovf_cnt, 0);
        repeat (300) step(1, 7, 1, 1, 0);
        chk("ovf_sat", ovf_cnt, 255);
        step(1, 7, 0, 1, 0);
        chk("ovf_full_noreq", ovf_cnt, 255);
        step(1, 7, 0, 0, 1);

        // Read pointer ahead of write pointer.
        repeat (5) step(0, 1, 0, 0, 0);
        chk("ahead_level", wr_level, 7);
`ifdef FIFO_WR_PTR_CHECK_EN
        chk("ahead_perr", ptr_err, 1);
`else
        chk("ahead_perr", ptr_err, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            wp = int'($urandom_range(0, 7));
            rg = int'($urandom_range(0, 7));
            step(wp, rg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-operation with data in flight.
        step(2, 6, 1, 1, 0);
        step(5, 3, 1, 1, 0);
        #2 wr_rst_n = 1'b0;
        #1 check_reset_vals("arst");
        model_reset();
        @(posedge wr_clk);
        #1 check_reset_vals("arst_hold");
        @(negedge wr_clk) wr_rst_n = 1'b1;
        step(2, 0, 0, 0, 0);
        chk("post_rst_level", wr_level, 2);
        step(2, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0);
        chk("post_rst_flush", wr_level, 2);
        for (int i = 0; i < 100; i++) begin
            step(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
